// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_pkg
//  Purpose  : Shared constants, types and helpers for the DES key schedule.
//             Contains the DES sizes, the per-round shift amounts, the PC-2
//             index table, the schedule state enum and the weak-key constants.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

   localparam int NUM_ROUNDS = 16;
   localparam int KEY_W      = 56;
   localparam int HALF_W     = 28;
   localparam int SUBKEY_W   = 48;
   localparam int RIDX_W     = 4;

   localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);

   // Left-rotation amount applied before round r (index r-1). Decrypt walks
   // the same table with right rotations; its first entry is forced to 0 so
   // the loaded key is already the round-16 C||D.
   localparam logic [1:0] SHIFT_AMT [NUM_ROUNDS] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // PC-2 selection, 1-based DES numbering into C||D (bit 1 = MSB).
   localparam int PC2_TAB [SUBKEY_W] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [KEY_W-1:0] WEAK_KEY_ZERO = 56'h00000000000000;
   localparam logic [KEY_W-1:0] WEAK_KEY_ONES = 56'hFFFFFFFFFFFFFF;
   localparam logic [KEY_W-1:0] WEAK_KEY_C0D1 = 56'h0000000FFFFFFF;
   localparam logic [KEY_W-1:0] WEAK_KEY_C1D0 = 56'hFFFFFFF0000000;

   function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                input logic [1:0]        amt);
      case (amt)
         2'd1:    return {x[HALF_W-2:0], x[HALF_W-1]};
         2'd2:    return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
         default: return x;
      endcase
   endfunction

   function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                input logic [1:0]        amt);
      case (amt)
         2'd1:    return {x[0], x[HALF_W-1:1]};
         2'd2:    return {x[1:0], x[HALF_W-1:2]};
         default: return x;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_sched_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : des_key_sched_seq_if
//  Purpose  : Key-load and subkey-stream bundle of the sequential DES key
//             schedule.
//  Signals  : load/ready/key_in/decrypt   - key acceptance handshake
//             subkey_valid/subkey_ready    - subkey stream handshake
//             subkey/round_idx             - current subkey and its index
//             done/weak_key                - completion pulse, weak-key flag
//  Modports : master (key source / subkey consumer), slave (schedule)
//  Revision : 1.0 - initial release
// ============================================================================
interface des_key_sched_seq_if;

   logic                          load;
   logic                          ready;
   logic [des_pkg::KEY_W-1:0]     key_in;
   logic                          decrypt;
   logic                          subkey_valid;
   logic                          subkey_ready;
   logic [des_pkg::SUBKEY_W-1:0]  subkey;
   logic [des_pkg::RIDX_W-1:0]    round_idx;
   logic                          done;
   logic                          weak_key;

   modport master (
      output load, key_in, decrypt, subkey_ready,
      input  ready, subkey_valid, subkey, round_idx, done, weak_key
   );

   modport slave (
      input  load, key_in, decrypt, subkey_ready,
      output ready, subkey_valid, subkey, round_idx, done, weak_key
   );

endinterface
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
//  Module   : des_pc2
//  Purpose  : DES Permuted Choice 2, purely combinational 56 -> 48 bit
//             selection driven from the package table.
//  Ports    : i_cd     in  56  C||D, DES bit 1 = i_cd[55]
//             o_subkey out 48  PC-2 output, position 1 = o_subkey[47]
//  Revision : 1.0 - initial release
// ============================================================================
module des_pc2
   import des_pkg::*;
(
   input  logic [KEY_W-1:0]    i_cd,
   output logic [SUBKEY_W-1:0] o_subkey
);

   for (genvar i = 0; i < SUBKEY_W; i++) begin : g_bit
      assign o_subkey[SUBKEY_W-1-i] = i_cd[KEY_W - PC2_TAB[i]];
   end

   // PC-2 drops DES positions 9, 18, 22, 25, 35, 38, 43 and 54.
   logic w_unused_bits;
   assign w_unused_bits = ^{i_cd[47], i_cd[38], i_cd[34], i_cd[31],
                            i_cd[21], i_cd[18], i_cd[13], i_cd[2]};

endmodule
`default_nettype wire

// File: rtl/des_key_sched_seq.sv
`default_nettype none
// ============================================================================
//  Module   : des_key_sched_seq
//  Purpose  : Sequential DES key schedule. Accepts a post-PC-1 56-bit key and
//             emits the 16 round subkeys one per handshake, in encrypt order
//             (K1..K16, left rotations) or decrypt order (K16..K1, right
//             rotations), keeping only the running C||D register.
//  Ports    : clk    in  1   rising-edge clock
//             rst_n  in  1   asynchronous active-low reset
//             bus    slave   des_key_sched_seq_if (load/ready/key_in/decrypt,
//                            subkey_valid/subkey_ready/subkey/round_idx,
//                            done, weak_key)
//  Options  : DES_WEAK_KEY_DET_EN - enables the registered weak-key flag;
//             when undefined weak_key is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module des_key_sched_seq
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   des_key_sched_seq_if.slave  bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [HALF_W-1:0]   r_c;
   logic [HALF_W-1:0]   r_d;
   logic [RIDX_W-1:0]   r_round;
   logic [RIDX_W-1:0]   w_round_nxt;
   logic                r_decrypt;
   logic                r_done;
   logic                w_ready;
   logic                w_valid;
   logic                w_accept;
   logic                w_step;
   logic                w_last_hs;
   logic [1:0]          w_amt;
   logic [KEY_W-1:0]    w_cd;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM: next state and handshake decode
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_valid     = 1'b0;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last_hs   = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (bus.load) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_valid = 1'b1;
            if (bus.subkey_ready) begin
               if (r_round == LAST_IDX) begin
                  w_last_hs   = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_step = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Rotation for the round about to be presented.
   assign w_round_nxt = r_round + RIDX_W'(1);
   assign w_amt       = SHIFT_AMT[w_round_nxt];

   // ------------------------------------------------------------------
   // C/D datapath, round counter, done pulse
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c       <= '0;
         r_d       <= '0;
         r_round   <= '0;
         r_decrypt <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_last_hs;
         if (w_accept) begin
            r_decrypt <= bus.decrypt;
            r_round   <= '0;
            // Decrypt starts from the untouched key: 28 total rotations make
            // it equal to the round-16 C||D.
            if (bus.decrypt) begin
               r_c <= bus.key_in[KEY_W-1:HALF_W];
               r_d <= bus.key_in[HALF_W-1:0];
            end else begin
               r_c <= rotl28(bus.key_in[KEY_W-1:HALF_W], SHIFT_AMT[0]);
               r_d <= rotl28(bus.key_in[HALF_W-1:0],     SHIFT_AMT[0]);
            end
         end else if (w_step) begin
            r_round <= w_round_nxt;
            if (r_decrypt) begin
               r_c <= rotr28(r_c, w_amt);
               r_d <= rotr28(r_d, w_amt);
            end else begin
               r_c <= rotl28(r_c, w_amt);
               r_d <= rotl28(r_d, w_amt);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Subkey: PC-2 of the C/D flops only
   // ------------------------------------------------------------------
   assign w_cd = {r_c, r_d};

   des_pc2 u_pc2 (
      .i_cd     (w_cd),
      .o_subkey (bus.subkey)
   );

   assign bus.ready        = w_ready;
   assign bus.subkey_valid = w_valid;
   assign bus.round_idx    = r_round;
   assign bus.done         = r_done;

   // ------------------------------------------------------------------
   // Weak-key flag
   // ------------------------------------------------------------------
`ifdef DES_WEAK_KEY_DET_EN
   logic r_weak;
   logic w_is_weak;

   assign w_is_weak = (bus.key_in == WEAK_KEY_ZERO) ||
                      (bus.key_in == WEAK_KEY_ONES) ||
                      (bus.key_in == WEAK_KEY_C0D1) ||
                      (bus.key_in == WEAK_KEY_C1D0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_weak <= 1'b0;
      else if (w_accept) r_weak <= w_is_weak;
   end

   assign bus.weak_key = r_weak;
`else
   assign bus.weak_key = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
- Sequential DES key schedule that sits directly downstream of the key-trojan stage and consumes its 56-bit payload (post-PC-1 key, C||D).
- Emits the 16 round subkeys (48-bit, post-PC-2), one per handshake, to the round datapath.
- Supports encrypt order (K1..K16, left rotations) and decrypt order (K16..K1, right rotations) without storing all 16 subkeys.

Parameters:
- NUM_ROUNDS, 16, number of subkeys emitted per key; fixed by DES, and only 16 is legal.
- KEY_W, 56, input key width (C = key_in[55:28], D = key_in[27:0]).
- SUBKEY_W, 48, subkey width.

Ports:
- clk  in  1  single clock; all flops rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  request to accept key_in/decrypt.
- ready  out  1  high in IDLE; load accepted when load && ready.
- key_in  in  56  key from the trojan stage payload, MSB-first DES bit numbering (bit 1 = key_in[55]).
- decrypt  in  1  0 = encrypt order, 1 = decrypt order; sampled at accept.
- subkey_valid  out  1  subkey/round_idx valid.
- subkey_ready  in  1  consumer accepts the current subkey when subkey_valid && subkey_ready.
- subkey  out  48  PC-2 of the current C||D register; PC-2 position 1 = subkey[47].
- round_idx  out  4  0..15, index of the emitted subkey in emission order.
- done  out  1  one-cycle pulse after the 16th subkey handshake.
- weak_key  out  1  weak-key flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - C, D, round_idx and subkey are 0.
  - ready=1; subkey_valid, done and weak_key are 0.
- States:
  - IDLE: ready=1, subkey_valid=0.
  - RUN: ready=0, subkey_valid=1.
- IDLE -> RUN on load && ready at edge T.
  - C/D are loaded already shifted for the first round: encrypt rotl 1; decrypt no shift.
  - The mode is latched; round_idx=0.
  - First subkey is valid at T+1, so latency is 1 cycle.
- RUN, on a handshake:
  - If round_idx==15: go to IDLE and set done=1 for exactly one cycle (the cycle ready returns high).
  - Otherwise increment round_idx and apply the next round's rotation to C and D independently (28-bit rotates).
- Encrypt shift amounts, per round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, all rotl.
- Decrypt shift amounts, per round 1..16: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, all rotr.
  - This reproduces K16 first, because C/D rotate a total of 28 over the 16 rounds.
- Stall: with subkey_valid && !subkey_ready, subkey, round_idx and C/D hold stable.
- No backpressure: 16 subkeys at T+1..T+16; done at T+17; a new load can be accepted at T+17.
- load while busy (ready=0): ignored, not queued; key_in and decrypt are don't-care.
- Reset asserted mid-operation: immediate return to IDLE; the partial sequence is discarded and no done pulse is generated.
- subkey is combinational from the C/D flops only (no input-to-output path).

Optional Feature:
- Macro: DES_WEAK_KEY_DET_EN.
- Defined:
  - At accept, weak_key is registered to 1 if key_in is one of the four DES weak keys in 56-bit form: all-0, all-1, C=0/D=all-1, C=all-1/D=0.
  - Otherwise weak_key is registered to 0.
  - weak_key holds until the next accept or reset.
- Undefined: weak_key is tied to 0, with no detection logic. The port is present in both builds.

Decomposition:
- Shared package des_pkg:
  - KEY_W, SUBKEY_W, NUM_ROUNDS.
  - 16-entry shift-amount constant.
  - PC-2 index table (48 entries, 1-based DES numbering).
  - State enum {IDLE, RUN}.
  - The four weak-key constants.
- One sub-module: des_pc2 (purely combinational 56->48 permutation driven from the package table), reusable by any later full-unrolled schedule.

Test Plan:
- Encrypt, key_in=0xF0CCAAF556678F, subkey_ready=1 -> K1 (round_idx 0, cycle T+1) = 0x1B02EFFC7072; K16 (round_idx 15, T+16) = 0xCB3D8B0E17F5; done pulses at T+17.
- Same key, decrypt=1 -> round_idx 0 = 0xCB3D8B0E17F5; round_idx 15 = 0x1B02EFFC7072; full sequence is the exact reverse of encrypt.
- Trojan-modified key 0xF0CCAAF556678E, encrypt -> 16 subkeys emitted with correct timing; at least one subkey differs from the unmodified-key sequence. Compare against the reference model.
- Backpressure: drop subkey_ready for 3 cycles at round_idx 5 -> subkey and round_idx stable for those cycles; final sequence identical to the no-stall run; done delayed by 3 cycles.
- Mid-operation: load during RUN -> ignored. rst_n low at round_idx 7 -> ready=1, subkey_valid=0, subkey=0 immediately; no done. After release, a fresh load restarts at round_idx 0.
- With DES_WEAK_KEY_DET_EN:
  - key_in=0 -> weak_key=1 and all 16 subkeys = 0.
  - key_in=0xFFFFFFFFFFFFFF -> weak_key=1.
  - Key 0xF0CCAAF556678F -> weak_key=0.
  - Without the macro, weak_key=0 for all three keys.
